// File: rtl/gpu_cmd_controller.sv
// gpu_cmd_controller: decodes host opcodes into word-wise memory copies and
// kernel launches across a set of cores, with timeout and abort handling.
module gpu_cmd_controller #(
    parameter int data_width = 32,
    parameter int addr_width = 32,
    parameter int num_cores  = 4,
    parameter int MAX_PARAMS = 4,
    parameter int tmo_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_instr_valid,
    input  logic [31:0]           cpu_recv_instr,
    input  logic                  cpu_in_valid,
    input  logic [31:0]           cpu_in_data,
    output logic                  cpu_ready,
    output logic                  cpu_out_valid,
    output logic [31:0]           cpu_out_data,
    output logic [1:0]            status,
    output logic                  mem_wr_req,
    output logic                  mem_rd_req,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wr_data,
    input  logic                  mem_ack,
    input  logic [data_width-1:0] mem_rd_data,
    output logic [num_cores-1:0]  core_en,
    output logic                  core_clr,
    output logic                  core_set_pc_req,
    output logic [data_width-1:0] core_set_pc_addr,
    input  logic [num_cores-1:0]  core_halted,
    output logic                  kernel_done
);
    localparam int PW = $clog2(MAX_PARAMS);
    localparam int CW = tmo_width + 10;
    localparam logic [31:0] OP_COPY_TO = 32'd1;
    localparam logic [31:0] OP_LAUNCH  = 32'd3;
    localparam logic [31:0] OP_ABORT   = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_RECV_PARAMS, S_RECV_DATA, S_WR_WAIT, S_RD_WAIT, S_LAUNCH, S_RUN
    } state_t;

    state_t                r_state, w_next;
    logic [31:0]           r_params [MAX_PARAMS];
    logic [PW-1:0]         r_param_pos;
    logic                  r_launch, r_to_gpu;
    logic [addr_width-1:0] r_addr;
    logic [31:0]           r_left;
    logic [data_width-1:0] r_wdata;
    logic [31:0]           r_out_data;
    logic                  r_out_valid;
    logic [1:0]            r_status;
    logic [num_cores-1:0]  r_core_en;
    logic [CW-1:0]         r_cnt;
    logic                  r_kdone;

    logic                  w_abort, w_op_ok, w_in_param, w_last_param, w_param_done;
    logic                  w_halt_all, w_tmo_hit, w_run_end;
    logic [31:0]           w_words;
    logic [tmo_width-1:0]  w_tmo;

    assign w_abort      = cpu_instr_valid && cpu_recv_instr == OP_ABORT && r_state != S_IDLE;
    assign w_op_ok      = cpu_recv_instr >= OP_COPY_TO && cpu_recv_instr <= OP_LAUNCH;
    assign w_in_param   = r_state == S_RECV_PARAMS && cpu_in_valid;
    assign w_last_param = r_param_pos == (r_launch ? PW'(2) : PW'(1));
    assign w_param_done = w_in_param && w_last_param;
    // byte count rounded up to whole words; 33-bit sum avoids losing the carry
    assign w_words      = 32'(({1'b0, cpu_in_data} + 33'd3) >> 2);
    assign w_halt_all   = (core_halted & r_core_en) == r_core_en;
    assign w_tmo        = r_params[2][tmo_width-1:0];
    assign w_tmo_hit    = w_tmo != '0 && r_cnt == {w_tmo, 10'd0} - CW'(1);
    assign w_run_end    = r_state == S_RUN && (w_halt_all || w_tmo_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) w_next = S_IDLE;
        else case (r_state)
            S_IDLE:        w_next = cpu_instr_valid && w_op_ok ? S_RECV_PARAMS : S_IDLE;
            S_RECV_PARAMS: if (w_param_done)
                               w_next = r_launch ? S_LAUNCH : w_words == 32'd0 ? S_IDLE :
                                        r_to_gpu ? S_RECV_DATA : S_RD_WAIT;
            S_RECV_DATA:   w_next = cpu_in_valid ? S_WR_WAIT : S_RECV_DATA;
            S_WR_WAIT:     if (mem_ack) w_next = r_left == 32'd1 ? S_IDLE : S_RECV_DATA;
            S_RD_WAIT:     if (mem_ack && r_left == 32'd1) w_next = S_IDLE;
            S_LAUNCH:      w_next = S_RUN;
            S_RUN:         w_next = w_run_end ? S_IDLE : S_RUN;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_params    <= '{default: '0};
            r_param_pos <= '0;
            r_launch    <= 1'b0;
            r_to_gpu    <= 1'b0;
            r_addr      <= '0;
            r_left      <= '0;
            r_wdata     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_status    <= 2'd0;
            r_core_en   <= '0;
            r_cnt       <= '0;
            r_kdone     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_kdone     <= 1'b0;
            if (r_state == S_IDLE && cpu_instr_valid) begin
                if (w_op_ok) begin
                    r_status    <= 2'd0;
                    r_param_pos <= '0;
                    r_launch    <= cpu_recv_instr == OP_LAUNCH;
                    r_to_gpu    <= cpu_recv_instr == OP_COPY_TO;
                end else if (cpu_recv_instr > OP_ABORT) begin
                    r_status <= 2'd1;
                end
            end
            if (w_abort) begin
                r_status  <= 2'd3;
                r_core_en <= '0;
                r_kdone   <= r_state == S_RUN;
            end else begin
                if (w_in_param) begin
                    r_params[r_param_pos] <= cpu_in_data;
                    r_param_pos           <= r_param_pos + PW'(1);
                end
                if (w_param_done) begin
                    r_addr <= addr_width'(r_params[0]);
                    r_left <= w_words;
                end
                if (r_state == S_RECV_DATA && cpu_in_valid) r_wdata <= data_width'(cpu_in_data);
                if ((r_state == S_WR_WAIT || r_state == S_RD_WAIT) && mem_ack) begin
                    r_addr <= r_addr + addr_width'(4);
                    r_left <= r_left - 32'd1;
                end
                if (r_state == S_RD_WAIT && mem_ack) begin
                    r_out_data  <= 32'(mem_rd_data);
                    r_out_valid <= 1'b1;
                end
                if (r_state == S_LAUNCH) begin
                    r_core_en <= r_params[1][num_cores-1:0];
                    r_cnt     <= '0;
                end
                if (r_state == S_RUN) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_run_end) begin
                        r_core_en <= '0;
                        r_kdone   <= 1'b1;
                        r_status  <= w_halt_all ? 2'd0 : 2'd2;
                    end
                end
            end
        end
    end

    assign cpu_ready        = r_state == S_IDLE ||
                              ((r_state == S_RECV_PARAMS || r_state == S_RECV_DATA) && cpu_in_valid);
    assign cpu_out_valid    = r_out_valid;
    assign cpu_out_data     = r_out_data;
    assign status           = r_status;
    assign mem_wr_req       = r_state == S_WR_WAIT;
    assign mem_rd_req       = r_state == S_RD_WAIT;
    assign mem_addr         = r_addr;
    assign mem_wr_data      = r_wdata;
    assign core_en          = r_core_en;
    assign core_clr         = r_state == S_LAUNCH;
    assign core_set_pc_req  = r_state == S_LAUNCH;
    assign core_set_pc_addr = r_state == S_LAUNCH ? data_width'(r_params[0]) : '0;
    assign kernel_done      = r_kdone;
endmodule

// File: doc/gpu_cmd_controller.md
GPU_CMD_CONTROLLER -- requirements
Module: gpu_cmd_controller

Interface
REQ-001 SHALL have parameters: data_width, default 32, data word width; addr_width, default 32, byte address width; num_cores, default 4, cores driven; MAX_PARAMS, default 4, parameter slots; tmo_width, default 16, timeout field width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 cpu_instr_valid  input  1  cpu_recv_instr valid this cycle.
REQ-006 cpu_recv_instr  input  32  opcode.
REQ-007 cpu_in_valid  input  1  cpu_in_data valid this cycle.
REQ-008 cpu_in_data  input  32  parameter or payload word.
REQ-009 cpu_ready  output  1  high when IDLE; also high while a parameter or payload word is accepted.
REQ-010 cpu_out_valid  output  1  cpu_out_data valid.
REQ-011 cpu_out_data  output  32  readback word.
REQ-012 status  output  2  0 ok, 1 bad opcode, 2 timeout, 3 aborted; sticky until next accepted opcode.
REQ-013 mem_wr_req, mem_rd_req  output  1 each  memory requests, held until mem_ack.
REQ-014 mem_addr  output  addr_width  request byte address.
REQ-015 mem_wr_data  output  data_width  write data.
REQ-016 mem_ack  input  1  request completed; mem_rd_data valid in that cycle.
REQ-017 mem_rd_data  input  data_width  read data.
REQ-018 core_en  output  num_cores  per-core enable.
REQ-019 core_clr  output  1  one-cycle clear pulse to cores.
REQ-020 core_set_pc_req  output  1  one-cycle PC load pulse.
REQ-021 core_set_pc_addr  output  data_width  kernel start address.
REQ-022 core_halted  input  num_cores  per-core halt flags.
REQ-023 kernel_done  output  1  one-cycle pulse at kernel end (normal, timeout or abort).

Function
REQ-024 Opcodes SHALL be: NOP=0; COPY_TO_GPU=1 (addr, bytes); COPY_FROM_GPU=2 (addr, bytes); KERNEL_LAUNCH=3 (pc, core_mask, timeout); ABORT=4 (none).
REQ-025 States SHALL be IDLE, RECV_PARAMS, RECV_DATA, WR_WAIT, RD_WAIT, LAUNCH, RUN.
REQ-026 In IDLE, cpu_instr_valid with opcode 1-3 SHALL go to RECV_PARAMS and clear status; NOP stays IDLE; ABORT in IDLE is a no-op; any other opcode SHALL set status=1 and stay IDLE.
REQ-027 RECV_PARAMS SHALL store one parameter per cycle with cpu_in_valid high, param_pos incrementing 0..n-1; no cpu_in_valid means wait.
REQ-028 Transfer end address SHALL be addr + byte count rounded up to a multiple of 4, modulo 2^addr_width; addresses advance by 4 per word and wrap.
REQ-029 A byte count of 0 SHALL return to IDLE with no memory request.
REQ-030 COPY_TO_GPU: RECV_DATA accepts a word on cpu_in_valid, issues mem_wr_req, enters WR_WAIT; on mem_ack returns to RECV_DATA or, after the last word, IDLE.
REQ-031 cpu_ready SHALL be low in WR_WAIT, RD_WAIT, LAUNCH and RUN.
REQ-032 COPY_FROM_GPU: RD_WAIT issues mem_rd_req; on mem_ack cpu_out_data is registered from mem_rd_data with cpu_out_valid high for exactly the next cycle; the next request issues that cycle; after the last word, go to IDLE.
REQ-033 Exactly one memory request SHALL be outstanding; mem_wr_req and mem_rd_req never high together.
REQ-034 LAUNCH SHALL pulse core_clr and core_set_pc_req in the same cycle with core_set_pc_addr=pc, then enter RUN with core_en=core_mask[num_cores-1:0].
REQ-035 RUN SHALL end when every enabled core has core_halted high: core_en cleared, kernel_done pulsed, go to IDLE, status=0.
REQ-036 Timeout field 0 SHALL disable timeout; otherwise RUN ends after timeout*1024 cycles with status=2, when not already ended per REQ-035 (halt wins in the same cycle).
REQ-037 core_mask of 0 SHALL end RUN on its first cycle with status=0.
REQ-038 ABORT on cpu_instr_valid in any non-IDLE state SHALL, next cycle, drop all requests, clear core_en, set status=3, go to IDLE, and pulse kernel_done if in RUN.
REQ-039 An ABORT during WR_WAIT/RD_WAIT SHALL discard the pending mem_ack.
REQ-040 Non-ABORT opcodes outside IDLE SHALL be ignored.

Reset
REQ-041 On rst low, asynchronously: state IDLE, all outputs 0 except cpu_ready=1, params and counters 0.
REQ-042 Reset mid-transfer or mid-kernel SHALL drop requests immediately; no pending operation resumes.

Verification
REQ-043 COPY_TO_GPU addr 0x100 bytes 12 data 7,8,9, mem_ack after 2 cycles -> writes 0x100=7, 0x104=8, 0x108=9, then IDLE.
REQ-044 COPY_FROM_GPU addr 0x100 bytes 6 -> two reads (0x100, 0x104), two cpu_out_valid pulses with stored data.
REQ-045 KERNEL_LAUNCH pc 0x400 mask 0b0101 timeout 0; halt cores 0,2 -> core_en 0b0101, one kernel_done, status 0.
REQ-046 KERNEL_LAUNCH timeout 1, no halts -> kernel_done 1024 cycles into RUN, status 2.
REQ-047 ABORT during WR_WAIT, then opcode 9 -> requests drop, status 3, then status 1.
REQ-048 rst low mid COPY_FROM_GPU -> outputs 0 immediately, cpu_ready 1.
